// File: rtl/boot_copier.sv
// boot_copier: copies the first WORDS bootrom words into RAM after reset, then
// becomes a transparent CPU->RAM bus switch.
//   clk, rst                 clock, asynchronous active-high reset
//   rom_cs/we/addr/din/dout  bootrom port (read only; we=0, din=0)
//   ram_cs/we/addr/din/dout  RAM port; ram_ready completes the access on an edge
//   cpu_cs/we/addr/din/dout  CPU port, forwarded to RAM only once done=1
//   cpu_hold                 stalls the CPU until the copy completes
//   done, err                copy complete / read-back mismatch (both sticky)
// Optional feature: define BOOT_VERIFY_EN to add a read-back verify pass that
// drives err; otherwise err is tied to 0.
module boot_copier #(
   parameter int WORDS    = 16,
   parameter int RAM_AW   = 8,
   parameter int RAM_BASE = 0
) (
   input  logic              clk,
   input  logic              rst,
   output logic              rom_cs,
   output logic              rom_we,
   output logic [3:0]        rom_addr,
   output logic [15:0]       rom_din,
   input  logic [15:0]       rom_dout,
   output logic              ram_cs,
   output logic              ram_we,
   output logic [RAM_AW-1:0] ram_addr,
   output logic [15:0]       ram_din,
   input  logic [15:0]       ram_dout,
   input  logic              ram_ready,
   input  logic              cpu_cs,
   input  logic              cpu_we,
   input  logic [RAM_AW-1:0] cpu_addr,
   input  logic [15:0]       cpu_din,
   output logic [15:0]       cpu_dout,
   output logic              cpu_hold,
   output logic              done,
   output logic              err
);
   localparam logic [2:0] IDLE   = 3'd0;
   localparam logic [2:0] RD_ROM = 3'd1;
   localparam logic [2:0] CAP    = 3'd2;
   localparam logic [2:0] WR_RAM = 3'd3;
   localparam logic [2:0] DONE   = 3'd4;
`ifdef BOOT_VERIFY_EN
   localparam logic [2:0] RD_RAM  = 3'd5;
   localparam logic [2:0] RD_ROM2 = 3'd6;
   localparam logic [2:0] CMP     = 3'd7;
`endif
   localparam logic [RAM_AW-1:0] BASE = RAM_AW'(RAM_BASE);
   localparam logic [3:0]        LAST = 4'(WORDS - 1);

   logic [2:0]  r_state;
   logic [3:0]  r_cnt;
   logic [15:0] r_data;
   logic        w_done, w_wr, w_rd, w_rom;
`ifdef BOOT_VERIFY_EN
   logic [15:0] r_rd;
   logic        r_err;
`endif

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state <= IDLE;
         r_cnt   <= '0;
         r_data  <= '0;
`ifdef BOOT_VERIFY_EN
         r_rd    <= '0;
         r_err   <= 1'b0;
`endif
      end else begin
         case (r_state)
            IDLE:   r_state <= RD_ROM;
            RD_ROM: r_state <= CAP;
            CAP: begin
               r_data  <= rom_dout;
               r_state <= WR_RAM;
            end
            WR_RAM: if (ram_ready) begin
               if (r_cnt == LAST) begin
`ifdef BOOT_VERIFY_EN
                  r_cnt   <= '0;
                  r_state <= RD_RAM;
`else
                  r_state <= DONE;
`endif
               end else begin
                  r_cnt   <= r_cnt + 4'd1;
                  r_state <= RD_ROM;
               end
            end
`ifdef BOOT_VERIFY_EN
            RD_RAM: if (ram_ready) begin
               r_rd    <= ram_dout;
               r_state <= RD_ROM2;
            end
            RD_ROM2: r_state <= CMP;
            CMP: begin
               if (r_rd != rom_dout) r_err <= 1'b1;
               if (r_cnt == LAST) r_state <= DONE;
               else begin
                  r_cnt   <= r_cnt + 4'd1;
                  r_state <= RD_RAM;
               end
            end
`endif
            default: r_state <= r_state;
         endcase
      end
   end

   assign w_done = r_state == DONE;
   assign w_wr   = r_state == WR_RAM;
`ifdef BOOT_VERIFY_EN
   assign w_rd   = r_state == RD_RAM;
   assign w_rom  = r_state == RD_ROM || r_state == CAP || r_state == RD_ROM2;
   assign err    = r_err;
`else
   assign w_rd   = 1'b0;
   assign w_rom  = r_state == RD_ROM || r_state == CAP;
   assign err    = 1'b0;
`endif

   // Outputs decode from state so an asynchronous reset clears them at once.
   assign rom_cs   = w_rom;
   assign rom_we   = 1'b0;
   assign rom_din  = '0;
   assign rom_addr = w_rom ? r_cnt : '0;
   assign ram_cs   = w_done ? cpu_cs : (w_wr | w_rd);
   assign ram_we   = w_done ? cpu_we : w_wr;
   assign ram_addr = w_done ? cpu_addr : (w_wr | w_rd) ? BASE + RAM_AW'(r_cnt) : '0;
   assign ram_din  = w_done ? cpu_din : w_wr ? r_data : '0;
   assign cpu_dout = w_done ? ram_dout : '0;
   assign cpu_hold = !w_done;
   assign done     = w_done;
endmodule

// File: tb/tb_boot_copier.sv
// tb_boot_copier: directed, table-driven bench for boot_copier.
module tb_boot_copier;
   typedef struct {
      logic [7:0]  addr;
      logic [15:0] data;
   } vec_t;

   localparam logic [15:0] ROM [16] = '{
      16'hF200, 16'h4000, 16'hF800, 16'h1007, 16'hF400, 16'h3007, 16'h4000, 16'hBEEF,
      16'hA5A5, 16'h5A5A, 16'h1234, 16'h5678, 16'h9ABC, 16'hDEF0, 16'h0F0F, 16'hF0F0};
   localparam int VX = `ifdef BOOT_VERIFY_EN 1 `else 0 `endif ;

   logic clk = 1'b0, rst = 1'b1, clr = 1'b0, corrupt = 1'b0;
   logic [1:0] mode = 2'd0;
   always #5 clk = ~clk;

   logic        rom_cs0, rom_we0, ram_cs0, ram_we0, rdy0, hold0, done0, err0;
   logic [3:0]  rom_addr0;
   logic [15:0] rom_din0, rom_dout0 = '0, ram_din0, ram_dout0, cpu_dout0;
   logic [7:0]  ram_addr0;
   logic        cpu_cs = 1'b0, cpu_we = 1'b0;
   logic [7:0]  cpu_addr = '0;
   logic [15:0] cpu_din = '0;

   logic        rom_cs1, rom_we1, ram_cs1, ram_we1, hold1, done1, err1;
   logic [3:0]  rom_addr1;
   logic [15:0] rom_din1, rom_dout1 = '0, ram_din1, ram_dout1, cpu_dout1;
   logic [7:0]  ram_addr1;

   boot_copier #(.WORDS(7), .RAM_AW(8), .RAM_BASE(0)) u0 (
      .clk(clk), .rst(rst),
      .rom_cs(rom_cs0), .rom_we(rom_we0), .rom_addr(rom_addr0), .rom_din(rom_din0), .rom_dout(rom_dout0),
      .ram_cs(ram_cs0), .ram_we(ram_we0), .ram_addr(ram_addr0), .ram_din(ram_din0), .ram_dout(ram_dout0),
      .ram_ready(rdy0),
      .cpu_cs(cpu_cs), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_din(cpu_din), .cpu_dout(cpu_dout0),
      .cpu_hold(hold0), .done(done0), .err(err0));

   boot_copier #(.WORDS(4), .RAM_AW(8), .RAM_BASE(8'hFE)) u1 (
      .clk(clk), .rst(rst),
      .rom_cs(rom_cs1), .rom_we(rom_we1), .rom_addr(rom_addr1), .rom_din(rom_din1), .rom_dout(rom_dout1),
      .ram_cs(ram_cs1), .ram_we(ram_we1), .ram_addr(ram_addr1), .ram_din(ram_din1), .ram_dout(ram_dout1),
      .ram_ready(1'b1),
      .cpu_cs(1'b0), .cpu_we(1'b0), .cpu_addr(8'h00), .cpu_din(16'h0000), .cpu_dout(cpu_dout1),
      .cpu_hold(hold1), .done(done1), .err(err1));

   // synchronous bootrom: data valid the cycle after rom_cs
   always @(posedge clk) begin
      if (rom_cs0) rom_dout0 <= ROM[rom_addr0];
      if (rom_cs1) rom_dout1 <= ROM[rom_addr1];
   end

   logic [15:0] ram0 [256];
   logic [15:0] ram1 [256];
   logic [7:0]  wa [64];
   logic [15:0] wd [64];
   int wn = 0, wcnt = 0, bad = 0;

   always_comb rdy0 = mode == 2'd0 ? 1'b1 : mode == 2'd2 ? 1'b0 : (!(ram_cs0 && ram_we0) || wcnt == 2);
   assign ram_dout0 = ram0[ram_addr0];
   assign ram_dout1 = ram1[ram_addr1];

   always @(posedge clk) begin
      if (clr) begin
         for (int i = 0; i < 256; i++) begin
            ram0[i] <= '0;
            ram1[i] <= '0;
         end
         wn <= 0;
      end else begin
         if (ram_cs0 && ram_we0 && rdy0) begin
            ram0[ram_addr0] <= (corrupt && ram_addr0 == 8'd2) ? 16'h0000 : ram_din0;
            if (wn < 64) begin
               wa[wn] <= ram_addr0;
               wd[wn] <= ram_din0;
            end
            wn <= wn + 1;
         end
         if (ram_cs1 && ram_we1) ram1[ram_addr1] <= ram_din1;
      end
      wcnt <= (ram_cs0 && ram_we0 && !rdy0) ? wcnt + 1 : 0;
   end

   // bootrom must never be written, and must be idle once the copy is done
   always @(negedge clk)
      if (rom_we0 || rom_we1 || rom_din0 != 0 || rom_din1 != 0 || (done0 && rom_cs0) || (done1 && rom_cs1))
         bad <= bad + 1;

   int total = 0, passed = 0;
   vec_t img [7];
   vec_t wrap [6];

   task automatic chk(input string n, input logic [31:0] a, input logic [31:0] e);
      total++;
      if (a === e) passed++;
      else $display("FAIL %s: got %0h expected %0h", n, a, e);
   endtask

   task automatic start();
      rst = 1'b1;
      clr = 1'b1;
      @(negedge clk);
      @(negedge clk);
      clr = 1'b0;
      rst = 1'b0;
   endtask

   task automatic wait_done(output int cyc);
      cyc = 0;
      while (!done0 && cyc < 400) begin
         @(posedge clk);
         cyc++;
         @(negedge clk);
      end
   endtask

   task automatic check_image();
      chk("write_count", wn, 7);
      for (int i = 0; i < 7; i++) begin
         chk($sformatf("ram[%0d]", img[i].addr), ram0[img[i].addr], img[i].data);
         chk($sformatf("log_addr%0d", i), wa[i], img[i].addr);
         chk($sformatf("log_data%0d", i), wd[i], img[i].data);
      end
   endtask

   initial begin
      int c, k;
      img = '{'{8'd0, 16'hF200}, '{8'd1, 16'h4000}, '{8'd2, 16'hF800}, '{8'd3, 16'h1007},
              '{8'd4, 16'hF400}, '{8'd5, 16'h3007}, '{8'd6, 16'h4000}};
      wrap = '{'{8'hFE, 16'hF200}, '{8'hFF, 16'h4000}, '{8'h00, 16'hF800}, '{8'h01, 16'h1007},
               '{8'h02, 16'h0000}, '{8'hFD, 16'h0000}};

      // reset values
      @(negedge clk);
      chk("rst_hold", hold0, 1);
      chk("rst_done", done0, 0);
      chk("rst_err", err0, 0);
      chk("rst_rom_cs", rom_cs0, 0);
      chk("rst_rom_addr", rom_addr0, 0);
      chk("rst_ram_cs", ram_cs0, 0);
      chk("rst_ram_we", ram_we0, 0);
      chk("rst_ram_addr", ram_addr0, 0);
      chk("rst_ram_din", ram_din0, 0);
      chk("rst_cpu_dout", cpu_dout0, 0);

      // copy with a CPU write held on the bus throughout
      cpu_cs = 1'b1; cpu_we = 1'b1; cpu_addr = 8'd3; cpu_din = 16'hFFFF;
      start();
      wait_done(c);
      chk("latency_fast", c, 22 + VX * 21);
      chk("hold_after", hold0, 0);
      chk("err_clean", err0, 0);
      check_image();
      @(negedge clk);
      cpu_cs = 1'b0;
      chk("cpu_write_after_done", ram0[3], 16'hFFFF);
      cpu_we = 1'b0; cpu_cs = 1'b1; cpu_addr = 8'd5;
      #1;
      chk("cpu_read", cpu_dout0, 16'h3007);
      chk("cpu_read_we", ram_we0, 0);
      cpu_cs = 1'b0;
      chk("wrap_done", done1, 1);
      for (int i = 0; i < 6; i++)
         chk($sformatf("wrap[%0h]", wrap[i].addr), ram1[wrap[i].addr], wrap[i].data);

      // RAM stalls two cycles on every write
      mode = 2'd1;
      start();
      wait_done(c);
      chk("latency_slow", c, 36 + VX * 21);
      check_image();
      mode = 2'd0;

      // reset in the middle of writing word 4
      start();
      k = 0;
      while (!(ram_cs0 && ram_we0 && ram_addr0 == 8'd4) && k < 200) begin
         @(negedge clk);
         k++;
      end
      chk("reach_word4", k < 200, 1);
      rst = 1'b1;
      #1;
      chk("abort_hold", hold0, 1);
      chk("abort_ram_cs", ram_cs0, 0);
      chk("abort_ram_we", ram_we0, 0);
      chk("abort_ram_addr", ram_addr0, 0);
      chk("abort_rom_cs", rom_cs0, 0);
      chk("abort_done", done0, 0);
      start();
      k = 0;
      while (!rom_cs0 && k < 50) begin
         @(negedge clk);
         k++;
      end
      chk("restart_rom_addr", rom_addr0, 0);
      wait_done(c);
      chk("latency_restart", c, 22 + VX * 21 - k);
      check_image();

      // ram_ready stuck low: stays in the first write
      mode = 2'd2;
      start();
      repeat (60) @(negedge clk);
      chk("stuck_done", done0, 0);
      chk("stuck_hold", hold0, 1);
      chk("stuck_we", ram_we0, 1);
      chk("stuck_addr", ram_addr0, 0);
      mode = 2'd0;

`ifdef BOOT_VERIFY_EN
      corrupt = 1'b1;
      start();
      wait_done(c);
      chk("verify_bad_done", done0, 1);
      chk("verify_bad_err", err0, 1);
      corrupt = 1'b0;
      start();
      wait_done(c);
      chk("verify_good_done", done0, 1);
      chk("verify_good_err", err0, 0);
`endif

      chk("rom_quiet", bad, 0);
      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end
endmodule
